mem_port_arbiter: RTL and testbench

//  Shares one single-port, fixed-latency unified memory between the IF stage (instruction fetch)
//  and the MEM stage (lw/sw) of the 5-stage MIPS pipeline. Sequences each access over
//  MEM_LATENCY cycles and returns read data with a one-cycle ack. Drives per-stage stall

---
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and data access.
// Data has priority; a last-grant bit alternates grants when both sides keep requesting.
//
//  state  | meaning
//  IDLE   | no access in flight; arbitrate and latch the winner's address/data
//  BUSY_I | fetch access on the memory bus, counter runs down to the last cycle
//  BUSY_D | data access on the memory bus, counter runs down to the last cycle
module mem_port_arbiter #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req_i,
   input  logic [ADDR_WIDTH-1:0] if_addr_i,
   output logic [DATA_WIDTH-1:0] if_rdata_o,
   output logic                  if_ack_o,
   output logic                  if_stall_o,
   input  logic                  dm_ren_i,
   input  logic                  dm_wen_i,
   input  logic [ADDR_WIDTH-1:0] dm_addr_i,
   input  logic [DATA_WIDTH-1:0] dm_wdata_i,
   output logic [DATA_WIDTH-1:0] dm_rdata_o,
   output logic                  dm_ack_o,
   output logic                  dm_stall_o,
   output logic                  mem_cs_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-3:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_din_o,
   input  logic [DATA_WIDTH-1:0] mem_dout_i
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_BUSY_I = 2'd1;
   localparam logic [1:0] S_BUSY_D = 2'd2;

   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

   logic [1:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  last_dm_q, last_dm_d;
   logic                  if_ack_q, if_ack_d;
   logic                  dm_ack_q, dm_ack_d;
   logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
   logic                  mem_cs_q, mem_cs_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-3:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;

   logic dm_pend;
   logic pick_dm;
   logic pick_if;
   logic unused_addr_bits;

   assign unused_addr_bits = ^{if_addr_i[1:0], dm_addr_i[1:0]};

   assign dm_pend = dm_ren_i | dm_wen_i;
   // Data wins unless it won last time and fetch is also waiting.
   assign pick_dm = dm_pend & (~if_req_i | ~last_dm_q);
   assign pick_if = if_req_i & ~pick_dm;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_dm_d  = last_dm_q;
      if_ack_d   = 1'b0;
      dm_ack_d   = 1'b0;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      mem_cs_d   = mem_cs_q;
      mem_we_d   = mem_we_q;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      case (state_q)
         S_IDLE: begin
            if (pick_dm) begin
               state_d    = S_BUSY_D;
               cnt_d      = CNT_INIT;
               last_dm_d  = 1'b1;
               mem_cs_d   = 1'b1;
               mem_we_d   = dm_wen_i;
               mem_addr_d = dm_addr_i[ADDR_WIDTH-1:2];
               mem_din_d  = dm_wdata_i;
            end else if (pick_if) begin
               state_d    = S_BUSY_I;
               cnt_d      = CNT_INIT;
               last_dm_d  = 1'b0;
               mem_cs_d   = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = if_addr_i[ADDR_WIDTH-1:2];
            end
         end
         S_BUSY_I, S_BUSY_D: begin
            if (cnt_q == '0) begin
               state_d  = S_IDLE;
               mem_cs_d = 1'b0;
               mem_we_d = 1'b0;
               if (state_q == S_BUSY_I) begin
                  if_rdata_d = mem_dout_i;
                  if_ack_d   = 1'b1;
               end else begin
                  if (!mem_we_q) dm_rdata_d = mem_dout_i;
                  dm_ack_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d  = S_IDLE;
            mem_cs_d = 1'b0;
            mem_we_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         last_dm_q  <= 1'b0;
         if_ack_q   <= 1'b0;
         dm_ack_q   <= 1'b0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
         mem_cs_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_dm_q  <= last_dm_d;
         if_ack_q   <= if_ack_d;
         dm_ack_q   <= dm_ack_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
         mem_cs_q   <= mem_cs_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
      end
   end

   assign if_rdata_o = if_rdata_q;
   assign if_ack_o   = if_ack_q;
   assign dm_rdata_o = dm_rdata_q;
   assign dm_ack_o   = dm_ack_q;
   assign mem_cs_o   = mem_cs_q;
   assign mem_we_o   = mem_we_q;
   assign mem_addr_o = mem_addr_q;
   assign mem_din_o  = mem_din_q;
   assign if_stall_o = if_req_i & ~if_ack_q;
   assign dm_stall_o = dm_pend & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected acks (data and cycle) are queued at
// request time and popped by a monitor whenever the DUT pulses an ack.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        if_stall;
   logic        dm_ren;
   logic        dm_wen;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        dm_stall;
   logic        mem_cs;
   logic        mem_we;
   logic [29:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;

   mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .if_req_i   (if_req),
      .if_addr_i  (if_addr),
      .if_rdata_o (if_rdata),
      .if_ack_o   (if_ack),
      .if_stall_o (if_stall),
      .dm_ren_i   (dm_ren),
      .dm_wen_i   (dm_wen),
      .dm_addr_i  (dm_addr),
      .dm_wdata_i (dm_wdata),
      .dm_rdata_o (dm_rdata),
      .dm_ack_o   (dm_ack),
      .dm_stall_o (dm_stall),
      .mem_cs_o   (mem_cs),
      .mem_we_o   (mem_we),
      .mem_addr_o (mem_addr),
      .mem_din_o  (mem_din),
      .mem_dout_i (mem_dout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: preloaded on the first edge, written whenever cs & we.
   logic [31:0] tb_mem [0:255];
   bit          mem_loaded = 1'b0;
   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 256; i++) tb_mem[i] <= 32'h0;
         tb_mem[4]  <= 32'h2008_0005;
         tb_mem[8]  <= 32'h1111_2222;
         mem_loaded <= 1'b1;
      end else if (mem_cs && mem_we) begin
         tb_mem[mem_addr[7:0]] <= mem_din;
      end
   end
   assign mem_dout = mem_cs ? tb_mem[mem_addr[7:0]] : 32'hBAD0_BAD0;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t q_if[$];
   exp_t q_dm[$];
   exp_t e_if;
   exp_t e_dm;
   int   n_chk = 0;
   int   n_err = 0;

   always @(negedge clk) begin
      if (if_ack) begin
         n_chk++;
         if (q_if.size() == 0) begin
            n_err++;
            $display("FAIL if_ack_unexpected at cycle %0d rdata=%h", cyc, if_rdata);
         end else begin
            e_if = q_if.pop_front();
            if (if_rdata !== e_if.data || cyc != e_if.cyc) begin
               n_err++;
               $display("FAIL if_ack got rdata=%h cycle=%0d expected rdata=%h cycle=%0d",
                        if_rdata, cyc, e_if.data, e_if.cyc);
            end
         end
      end
      if (dm_ack) begin
         n_chk++;
         if (q_dm.size() == 0) begin
            n_err++;
            $display("FAIL dm_ack_unexpected at cycle %0d rdata=%h", cyc, dm_rdata);
         end else begin
            e_dm = q_dm.pop_front();
            if (dm_rdata !== e_dm.data || cyc != e_dm.cyc) begin
               n_err++;
               $display("FAIL dm_ack got rdata=%h cycle=%0d expected rdata=%h cycle=%0d",
                        dm_rdata, cyc, e_dm.data, e_dm.cyc);
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_if(input logic [31:0] d, input int c);
      exp_t e;
      e.data = d;
      e.cyc  = c;
      q_if.push_back(e);
   endtask

   task automatic push_dm(input logic [31:0] d, input int c);
      exp_t e;
      e.data = d;
      e.cyc  = c;
      q_dm.push_back(e);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   int c;

   initial begin
      rst      = 1'b1;
      if_req   = 1'b0;
      if_addr  = 32'h0;
      dm_ren   = 1'b0;
      dm_wen   = 1'b0;
      dm_addr  = 32'h0;
      dm_wdata = 32'h0;

      // Reset held while fetch is requesting
      step();
      if_req  = 1'b1;
      if_addr = 32'h10;
      step();
      step();
      chk("rst_if_ack", {31'd0, if_ack}, 32'd0);
      chk("rst_dm_ack", {31'd0, dm_ack}, 32'd0);
      chk("rst_mem_cs", {31'd0, mem_cs}, 32'd0);
      chk("rst_if_stall", {31'd0, if_stall}, 32'd1);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_mem_addr", {2'b00, mem_addr}, 32'd0);
      rst    = 1'b0;
      if_req = 1'b0;

      // Fetch read
      step();
      if_req  = 1'b1;
      if_addr = 32'h0000_0010;
      c = cyc;
      push_if(32'h2008_0005, c + 3);
      step();
      chk("if_rd_cs_t1", {31'd0, mem_cs}, 32'd1);
      chk("if_rd_addr_t1", {2'b00, mem_addr}, 32'h4);
      chk("if_rd_we_t1", {31'd0, mem_we}, 32'd0);
      chk("if_rd_stall_t1", {31'd0, if_stall}, 32'd1);
      step();
      chk("if_rd_cs_t2", {31'd0, mem_cs}, 32'd1);
      chk("if_rd_addr_t2", {2'b00, mem_addr}, 32'h4);
      step();
      chk("if_rd_stall_ack", {31'd0, if_stall}, 32'd0);
      chk("if_rd_cs_ack", {31'd0, mem_cs}, 32'd0);
      if_req = 1'b0;

      // Data read from an unaligned address
      step();
      dm_ren  = 1'b1;
      dm_addr = 32'h23;
      c = cyc;
      push_dm(32'h1111_2222, c + 3);
      step();
      chk("ld_unaligned_addr", {2'b00, mem_addr}, 32'h8);
      chk("ld_dm_stall", {31'd0, dm_stall}, 32'd1);
      step();
      step();
      chk("ld_dm_stall_ack", {31'd0, dm_stall}, 32'd0);
      dm_ren = 1'b0;

      // Store: dm_rdata must keep the previous load value
      step();
      dm_wen   = 1'b1;
      dm_addr  = 32'h40;
      dm_wdata = 32'hDEAD_BEEF;
      c = cyc;
      push_dm(32'h1111_2222, c + 3);
      for (int k = 1; k <= 2; k++) begin
         step();
         chk("st_we", {31'd0, mem_we}, 32'd1);
         chk("st_addr", {2'b00, mem_addr}, 32'h10);
         chk("st_din", mem_din, 32'hDEAD_BEEF);
      end
      step();
      dm_wen = 1'b0;

      // Load back what was stored
      step();
      dm_ren  = 1'b1;
      dm_addr = 32'h40;
      c = cyc;
      push_dm(32'hDEAD_BEEF, c + 3);
      step();
      step();
      step();
      dm_ren = 1'b0;

      // ren and wen together behave as a write
      step();
      dm_ren   = 1'b1;
      dm_wen   = 1'b1;
      dm_addr  = 32'h44;
      dm_wdata = 32'h0BAD_F00D;
      c = cyc;
      push_dm(32'hDEAD_BEEF, c + 3);
      step();
      chk("rw_both_we", {31'd0, mem_we}, 32'd1);
      chk("rw_both_din", mem_din, 32'h0BAD_F00D);
      step();
      step();
      dm_ren = 1'b0;
      dm_wen = 1'b0;

      // Simultaneous requests after reset: data first, then fetch
      do_reset();
      step();
      if_req  = 1'b1;
      if_addr = 32'h10;
      dm_ren  = 1'b1;
      dm_addr = 32'h20;
      c = cyc;
      push_dm(32'h1111_2222, c + 3);
      push_if(32'h2008_0005, c + 6);
      step();
      chk("both_first_addr", {2'b00, mem_addr}, 32'h8);
      step();
      step();
      dm_ren = 1'b0;
      step();
      chk("both_second_addr", {2'b00, mem_addr}, 32'h4);
      step();
      step();
      if_req = 1'b0;

      // Both held continuously: grants alternate D, I, D, I
      do_reset();
      step();
      if_req  = 1'b1;
      if_addr = 32'h10;
      dm_ren  = 1'b1;
      dm_addr = 32'h20;
      c = cyc;
      push_dm(32'h1111_2222, c + 3);
      push_if(32'h2008_0005, c + 6);
      push_dm(32'h1111_2222, c + 9);
      push_if(32'h2008_0005, c + 12);
      for (int k = 1; k <= 12; k++) begin
         step();
         if (k % 3 == 1)
            chk("alt_grant_addr", {2'b00, mem_addr}, ((k / 3) % 2 == 0) ? 32'h8 : 32'h4);
      end
      if_req = 1'b0;
      dm_ren = 1'b0;

      // Reset in the middle of a data read aborts it without an ack
      do_reset();
      step();
      dm_ren  = 1'b1;
      dm_addr = 32'h20;
      step();
      chk("abort_cs_t1", {31'd0, mem_cs}, 32'd1);
      rst    = 1'b1;
      dm_ren = 1'b0;
      step();
      chk("abort_cs_t2", {31'd0, mem_cs}, 32'd0);
      chk("abort_dm_ack", {31'd0, dm_ack}, 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) step();
      chk("abort_dm_rdata", dm_rdata, 32'd0);

      chk("if_queue_drained", q_if.size(), 32'd0);
      chk("dm_queue_drained", q_dm.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
